fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 137 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Turns the read side of a synchronous FIFO (registered read data, one cycle
// of read latency) into a valid/ready stream. A 2-entry skid buffer absorbs
// the word still in flight when the downstream stalls, so the stream runs at
// one word per clock with no bubbles while the FIFO has data and m_ready
// stays high.
//
// Stream handshake:
//   A word moves downstream on every rising edge where m_valid and m_ready
//   are both high. Once m_valid is high, m_data and m_valid hold until that
//   transfer happens. m_valid does not depend on m_ready; fifo_r_en does.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   fifo_empty  in   empty flag of the upstream FIFO
//   fifo_data   in   FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en   out  FIFO read enable (combinational, depends on m_ready)
//   flush       in   synchronous discard of buffered and in-flight words
//   m_valid     out  downstream word available
//   m_ready     in   downstream accepts the word
//   m_data      out  downstream word (oldest buffered word)
//   rd_count    out  words delivered downstream, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_r_en,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [15:0]      rd_count
);

    // Output buffer: entry 0 is always the head, entry 1 the next word.
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             inf_q;
    logic             inf_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    logic             pop;
    logic             push;
    logic [2:0]       level;
    logic [2:0]       limit;
    logic [1:0]       slot;

    // A transfer in a flush cycle is not a pop: the word is discarded, not
    // delivered, so it must not be counted either.
    assign pop  = (occ_q != 2'd0) & m_ready & ~flush;
    // The word requested last cycle lands on fifo_data now; flush drops it.
    assign push = inf_q & ~flush;

    // Issue a read only if the buffer can take the return word next edge:
    // occ + inf - pop < 2, rewritten as occ + inf < 2 + pop to stay unsigned.
    assign level = {1'b0, occ_q} + {2'b00, inf_q};
    assign limit = 3'd2 + {2'b00, pop};

    // rst_n gates the read combinationally so nothing is requested from the
    // FIFO while reset is held, even with a non-empty FIFO.
    assign fifo_r_en = rst_n & ~fifo_empty & ~flush & (level < limit);

    // Tail slot for the returning word, counted after the head has shifted.
    assign slot = occ_q - {1'b0, pop};

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        occ_d    = occ_q;
        inf_d    = fifo_r_en;
        cnt_d    = cnt_q;

        if (flush) begin
            occ_d = 2'd0;
        end else begin
            if (pop) begin
                buf_d[0] = buf_q[1];
            end
            if (push) begin
                if (slot == 2'd0) begin
                    buf_d[0] = fifo_data;
                end else begin
                    buf_d[1] = fifo_data;
                end
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end

        if (pop) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            occ_q    <= 2'd0;
            inf_q    <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            occ_q    <= occ_d;
            inf_q    <= inf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[0];
    assign rd_count = cnt_q;

`ifndef SYNTHESIS
    // Buffer plus in-flight word can never exceed the two buffer slots.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) (level <= 3'd2)
    );
    a_no_read_empty : assert property (
        @(posedge clk) disable iff (!rst_n) !(fifo_r_en && fifo_empty)
    );
    a_occ_legal : assert property (
        @(posedge clk) disable iff (!rst_n) (occ_q != 2'd3)
    );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural synchronous FIFO
// (registered read data) feeding it.
module tb_fifo_rd_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_r_en;
  logic         flush = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [15:0]  rd_count;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count)
  );

  // upstream FIFO model: written by the stimulus, read at the clock edge
  logic [W-1:0] mem [16];
  logic [31:0]  wr_ptr = 0;
  logic [31:0]  rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // driver tasks
  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr[3:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // wrap-phase scoreboard: expected data stream of the long run
  logic [W-1:0] exp_q[$];
  int wrap_bad = 0;
  int wrap_got = 0;

  task automatic step_obs();
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0 || m_data !== exp_q[0]) wrap_bad++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      wrap_got++;
    end
  endtask

  initial begin
    int pushed;
    // ---------------- reset state, read blocked during reset
    m_ready = 1'b1;
    push(8'hA5);
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", {24'b0, m_data}, 32'd0);
    chk("rst_rd_count", {16'b0, rd_count}, 32'd0);
    chk("rst_r_en", {31'b0, fifo_r_en}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    // ---------------- single word 0xA5
    chk("single_r_en_t", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("single_r_en_t1", {31'b0, fifo_r_en}, 32'd0);
    chk("single_valid_t1", {31'b0, m_valid}, 32'd0);
    step();
    chk("single_valid_t2", {31'b0, m_valid}, 32'd1);
    chk("single_data_t2", {24'b0, m_data}, 32'hA5);
    step();
    chk("single_valid_after", {31'b0, m_valid}, 32'd0);
    chk("single_count", {16'b0, rd_count}, 32'd1);

    // ---------------- streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    chk("stream_r_en_c0", {31'b0, fifo_r_en}, 32'd1);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'b0, m_valid}, 32'd1);
      chk("stream_data", {24'b0, m_data}, 32'(i + 1));
      step();
    end
    chk("stream_valid_end", {31'b0, m_valid}, 32'd0);
    chk("stream_count", {16'b0, rd_count}, 32'd9);

    // ---------------- backpressure with 5 words queued
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    #1;
    chk("bp_r_en_c0", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("bp_r_en_c1", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("bp_r_en_c2", {31'b0, fifo_r_en}, 32'd0);
    chk("bp_data_c2", {24'b0, m_data}, 32'h01);
    step();
    chk("bp_r_en_c3", {31'b0, fifo_r_en}, 32'd0);
    chk("bp_hold_valid", {31'b0, m_valid}, 32'd1);
    chk("bp_hold_data", {24'b0, m_data}, 32'h01);
    step();
    chk("bp_hold_data2", {24'b0, m_data}, 32'h01);
    chk("bp_fifo_left", wr_ptr - rd_ptr, 32'd3);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, m_valid}, 32'd1);
      chk("bp_data", {24'b0, m_data}, 32'(i + 1));
      step();
    end
    chk("bp_valid_end", {31'b0, m_valid}, 32'd0);
    chk("bp_count", {16'b0, rd_count}, 32'd14);

    // ---------------- flush with one word buffered and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h31 + i));
    step();
    step();
    step();
    chk("fl_full_data", {24'b0, m_data}, 32'h31);
    chk("fl_full_r_en", {31'b0, fifo_r_en}, 32'd0);
    m_ready = 1'b1;
    #1;
    chk("fl_pop_r_en", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("fl_pre_data", {24'b0, m_data}, 32'h32);
    flush = 1'b1;
    #1;
    chk("fl_r_en_suppr", {31'b0, fifo_r_en}, 32'd0);
    step();
    flush = 1'b0;
    chk("fl_valid_next", {31'b0, m_valid}, 32'd0);
    chk("fl_count", {16'b0, rd_count}, 32'd15);
    #1;
    chk("fl_r_en_resume", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("fl_valid_gap", {31'b0, m_valid}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("fl_valid", {31'b0, m_valid}, 32'd1);
      chk("fl_data", {24'b0, m_data}, 32'(8'h34 + i));
      step();
    end
    chk("fl_valid_end", {31'b0, m_valid}, 32'd0);
    chk("fl_count_end", {16'b0, rd_count}, 32'd18);

    // ---------------- reset in the middle of a stream
    for (int i = 0; i < 8; i++) push(8'(8'h41 + i));
    step();
    step();
    step();
    step();
    chk("mr_pre_data", {24'b0, m_data}, 32'h43);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, m_valid}, 32'd0);
    chk("mr_data", {24'b0, m_data}, 32'd0);
    chk("mr_count", {16'b0, rd_count}, 32'd0);
    chk("mr_r_en", {31'b0, fifo_r_en}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_r_en_release", {31'b0, fifo_r_en}, 32'd1);
    step();
    chk("mr_no_stale", {31'b0, m_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("mr_valid_after", {31'b0, m_valid}, 32'd1);
      chk("mr_data_after", {24'b0, m_data}, 32'(8'h45 + i));
      step();
    end
    chk("mr_valid_end", {31'b0, m_valid}, 32'd0);
    chk("mr_count_end", {16'b0, rd_count}, 32'd4);

    // ---------------- counter wrap: 65535 transfers then one more
    rst_n = 1'b0;
    #1;
    chk("wr_rst_count", {16'b0, rd_count}, 32'd0);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    pushed = 0;
    for (int g = 0; g < 80000 && pushed < 65535; g++) begin
      if (wr_ptr - rd_ptr < 4) begin
        push(8'(pushed));
        exp_q.push_back(8'(pushed));
        pushed++;
      end
      step_obs();
    end
    repeat (8) step_obs();
    chk("wr_pushed", 32'(pushed), 32'd65535);
    chk("wr_order_bad", 32'(wrap_bad), 32'd0);
    chk("wr_delivered", 32'(wrap_got), 32'd65535);
    chk("wr_count_ffff", {16'b0, rd_count}, 32'h0000FFFF);
    push(8'hEE);
    repeat (6) step();
    chk("wr_count_wrap", {16'b0, rd_count}, 32'd0);
    chk("wr_valid_end", {31'b0, m_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
